// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory bridge port between IFU and LSU, one request in flight.
// Optional macro MEM_ARB_RR_EN replaces fixed LSU priority on ties with a round-robin last-grant pointer.
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              iClk,
  input  logic              iResetN,
  input  logic              iIfuReqValid,
  output logic              oIfuReqReady,
  input  logic [ADDR_W-1:0] iIfuAddr,
  output logic              oIfuRspValid,
  output logic [DATA_W-1:0] oIfuRspData,
  input  logic              iLsuReqValid,
  output logic              oLsuReqReady,
  input  logic              iLsuWrEn,
  input  logic [ADDR_W-1:0] iLsuAddr,
  input  logic [DATA_W-1:0] iLsuWrData,
  input  logic [7:0]        iLsuWrLen,
  output logic              oLsuRspValid,
  output logic [DATA_W-1:0] oLsuRspData,
  output logic [ADDR_W-1:0] oMemRdAddrInst,
  output logic [ADDR_W-1:0] oMemRdAddrLoad,
  input  logic [DATA_W-1:0] iMemRdDataInst,
  input  logic [DATA_W-1:0] iMemRdDataLoad,
  output logic              oMemWrEn,
  output logic [ADDR_W-1:0] oMemWrAddr,
  output logic [DATA_W-1:0] oMemWrData,
  output logic [7:0]        oMemWrLen
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              owner_lsu;
  logic              cap_wren;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rd_addr_inst;
  logic [ADDR_W-1:0] rd_addr_load;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [7:0]        wr_len;
  logic              grant_ifu;
  logic              grant_lsu;
  logic              accept;
  logic              rsp_fire;

`ifdef MEM_ARB_RR_EN
  logic last_lsu;

  // On a tie the requester not granted last wins; a lone requester always wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE) begin
      if (iIfuReqValid && iLsuReqValid) begin
        grant_ifu = last_lsu;
        grant_lsu = ~last_lsu;
      end else begin
        grant_ifu = iIfuReqValid;
        grant_lsu = iLsuReqValid;
      end
    end
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      last_lsu <= 1'b1;
    end else if (accept) begin
      last_lsu <= grant_lsu;
    end
  end
`else
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE) begin
      grant_lsu = iLsuReqValid;
      grant_ifu = iIfuReqValid & ~iLsuReqValid;
    end
  end
`endif

  assign accept = grant_ifu | grant_lsu;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = LAT_INIT;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Bridge-facing registers double as the request capture, so addresses hold after BUSY.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      owner_lsu    <= 1'b0;
      cap_wren     <= 1'b0;
      rd_addr_inst <= '0;
      rd_addr_load <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_len       <= 8'd0;
      rsp_data     <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        owner_lsu <= grant_lsu;
        cap_wren  <= grant_lsu & iLsuWrEn;
        if (grant_ifu) begin
          rd_addr_inst <= iIfuAddr;
        end else if (!iLsuWrEn) begin
          rd_addr_load <= iLsuAddr;
        end else begin
          wr_en   <= 1'b1;
          wr_addr <= iLsuAddr;
          wr_data <= iLsuWrData;
          wr_len  <= iLsuWrLen;
        end
      end
      if (state == BUSY && cnt == 4'd0) begin
        if (!owner_lsu) begin
          rsp_data <= iMemRdDataInst;
        end else if (cap_wren) begin
          rsp_data <= '0;
        end else begin
          rsp_data <= iMemRdDataLoad;
        end
      end
    end
  end

  // Readiness is masked while reset is held so nothing looks accepted during reset.
  assign oIfuReqReady = grant_ifu & iResetN;
  assign oLsuReqReady = grant_lsu & iResetN;

  assign rsp_fire     = (state == RESP);
  assign oIfuRspValid = rsp_fire & ~owner_lsu;
  assign oLsuRspValid = rsp_fire & owner_lsu;
  assign oIfuRspData  = oIfuRspValid ? rsp_data : '0;
  assign oLsuRspData  = oLsuRspValid ? rsp_data : '0;

  assign oMemRdAddrInst = rd_addr_inst;
  assign oMemRdAddrLoad = rd_addr_load;
  assign oMemWrEn       = wr_en;
  assign oMemWrAddr     = wr_addr;
  assign oMemWrData     = wr_data;
  assign oMemWrLen      = wr_len;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter (MEM_LAT=1 and MEM_LAT=3 instances).
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifu_valid;
  logic [63:0] ifu_addr;
  logic        lsu_valid;
  logic        lsu_wren;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_len;
  logic        lsu_valid3;

  logic        ifu_ready, ifu_rsp_valid, lsu_ready, lsu_rsp_valid, wr_en;
  logic [63:0] ifu_rsp_data, lsu_rsp_data, rd_inst, rd_load, mem_inst, mem_load, wr_addr, wr_data;
  logic [7:0]  wr_len;

  logic        ifu_ready3, ifu_rsp_valid3, lsu_ready3, lsu_rsp_valid3, wr_en3;
  logic [63:0] ifu_rsp_data3, lsu_rsp_data3, rd_inst3, rd_load3, mem_inst3, mem_load3, wr_addr3, wr_data3;
  logic [7:0]  wr_len3;

  int passed = 0;
  int total  = 0;

  // Bridge model: fixed instruction at the boot address, otherwise address-derived data.
  assign mem_inst  = (rd_inst == 64'h8000_0000) ? 64'h0010_0073 : rd_inst + 64'h1111;
  assign mem_load  = rd_load + 64'h2222;
  assign mem_inst3 = rd_inst3 + 64'h1111;
  assign mem_load3 = rd_load3 + 64'h2222;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut (
    .iClk(clk), .iResetN(rst_n),
    .iIfuReqValid(ifu_valid), .oIfuReqReady(ifu_ready), .iIfuAddr(ifu_addr),
    .oIfuRspValid(ifu_rsp_valid), .oIfuRspData(ifu_rsp_data),
    .iLsuReqValid(lsu_valid), .oLsuReqReady(lsu_ready), .iLsuWrEn(lsu_wren),
    .iLsuAddr(lsu_addr), .iLsuWrData(lsu_wdata), .iLsuWrLen(lsu_len),
    .oLsuRspValid(lsu_rsp_valid), .oLsuRspData(lsu_rsp_data),
    .oMemRdAddrInst(rd_inst), .oMemRdAddrLoad(rd_load),
    .iMemRdDataInst(mem_inst), .iMemRdDataLoad(mem_load),
    .oMemWrEn(wr_en), .oMemWrAddr(wr_addr), .oMemWrData(wr_data), .oMemWrLen(wr_len)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) dut3 (
    .iClk(clk), .iResetN(rst_n),
    .iIfuReqValid(1'b0), .oIfuReqReady(ifu_ready3), .iIfuAddr(ifu_addr),
    .oIfuRspValid(ifu_rsp_valid3), .oIfuRspData(ifu_rsp_data3),
    .iLsuReqValid(lsu_valid3), .oLsuReqReady(lsu_ready3), .iLsuWrEn(lsu_wren),
    .iLsuAddr(lsu_addr), .iLsuWrData(lsu_wdata), .iLsuWrLen(lsu_len),
    .oLsuRspValid(lsu_rsp_valid3), .oLsuRspData(lsu_rsp_data3),
    .oMemRdAddrInst(rd_inst3), .oMemRdAddrLoad(rd_load3),
    .iMemRdDataInst(mem_inst3), .iMemRdDataLoad(mem_load3),
    .oMemWrEn(wr_en3), .oMemWrAddr(wr_addr3), .oMemWrData(wr_data3), .oMemWrLen(wr_len3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic first_lsu;
  logic exp_lsu;

  initial begin
`ifdef MEM_ARB_RR_EN
    first_lsu = 1'b0;
`else
    first_lsu = 1'b1;
`endif
    rst_n = 1'b0; ifu_valid = 1'b1; lsu_valid = 1'b1; lsu_valid3 = 1'b0;
    ifu_addr = 64'h0; lsu_wren = 1'b0; lsu_addr = 64'h0; lsu_wdata = 64'h0; lsu_len = 8'd0;
    step(); step();
    // Reset: everything quiet even with requests pending.
    chk1("rst_ifu_ready", ifu_ready, 1'b0);
    chk1("rst_lsu_ready", lsu_ready, 1'b0);
    chk1("rst_outputs_zero", |{ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid, lsu_rsp_data,
                               rd_inst, rd_load, wr_en, wr_addr, wr_data, wr_len}, 1'b0);
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // IFU fetch, MEM_LAT=1.
    ifu_valid = 1'b1; ifu_addr = 64'h8000_0000; #1;
    chk1("f_ifu_ready", ifu_ready, 1'b1);
    chk1("f_lsu_ready", lsu_ready, 1'b0);
    step();
    ifu_valid = 1'b0; ifu_addr = 64'h0;
    chk64("f_rd_addr", rd_inst, 64'h8000_0000);
    chk1("f_busy_ready", ifu_ready, 1'b0);
    chk1("f_busy_rsp", ifu_rsp_valid, 1'b0);
    step();
    chk1("f_rsp_valid", ifu_rsp_valid, 1'b1);
    chk64("f_rsp_data", ifu_rsp_data, 64'h0010_0073);
    step();
    chk1("f_rsp_pulse_end", ifu_rsp_valid, 1'b0);
    chk64("f_rd_addr_hold", rd_inst, 64'h8000_0000);

    // LSU store.
    lsu_valid = 1'b1; lsu_wren = 1'b1; lsu_addr = 64'h8000_1000;
    lsu_wdata = 64'hDEAD_BEEF; lsu_len = 8'd4; #1;
    chk1("s_lsu_ready", lsu_ready, 1'b1);
    step();
    lsu_valid = 1'b0; lsu_wdata = 64'h5555; lsu_len = 8'd1; lsu_addr = 64'h0;
    chk1("s_wr_en", wr_en, 1'b1);
    chk64("s_wr_addr", wr_addr, 64'h8000_1000);
    chk64("s_wr_data", wr_data, 64'hDEAD_BEEF);
    chk64("s_wr_len", {56'h0, wr_len}, 64'd4);
    step();
    chk1("s_wr_en_once", wr_en, 1'b0);
    chk1("s_rsp_valid", lsu_rsp_valid, 1'b1);
    chk64("s_rsp_data", lsu_rsp_data, 64'h0);
    chk1("s_ifu_quiet", ifu_rsp_valid, 1'b0);
    chk64("s_wr_data_hold", wr_data, 64'hDEAD_BEEF);
    step();
    chk1("s_rsp_pulse_end", lsu_rsp_valid, 1'b0);

    // Simultaneous IFU fetch and LSU load, loser held until served.
    lsu_wren = 1'b0;
    ifu_valid = 1'b1; ifu_addr = 64'h8000_0004;
    lsu_valid = 1'b1; lsu_addr = 64'h8000_2000; #1;
    chk1("t_lsu_ready", lsu_ready, first_lsu);
    chk1("t_ifu_ready", ifu_ready, ~first_lsu);
    step();
    if (first_lsu) lsu_valid = 1'b0;
    else ifu_valid = 1'b0;
    step();
    chk1("t1_lsu_rsp", lsu_rsp_valid, first_lsu);
    chk1("t1_ifu_rsp", ifu_rsp_valid, ~first_lsu);
    chk64("t1_data", first_lsu ? lsu_rsp_data : ifu_rsp_data,
          first_lsu ? 64'h8000_4222 : 64'h8000_1115);
    step();
    chk1("t2_loser_ready", first_lsu ? ifu_ready : lsu_ready, 1'b1);
    step();
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    chk1("t2_lsu_rsp", lsu_rsp_valid, ~first_lsu);
    chk1("t2_ifu_rsp", ifu_rsp_valid, first_lsu);
    chk64("t2_data", first_lsu ? ifu_rsp_data : lsu_rsp_data,
          first_lsu ? 64'h8000_1115 : 64'h8000_4222);
    step();

    // Repeated ties: round-robin alternates from IFU, fixed priority always picks LSU.
    for (int r = 0; r < 4; r++) begin
`ifdef MEM_ARB_RR_EN
      exp_lsu = (r % 2 == 1);
`else
      exp_lsu = 1'b1;
`endif
      ifu_valid = 1'b1; lsu_valid = 1'b1; #1;
      chk1($sformatf("rr%0d_lsu_ready", r), lsu_ready, exp_lsu);
      chk1($sformatf("rr%0d_ifu_ready", r), ifu_ready, ~exp_lsu);
      step();
      ifu_valid = 1'b0; lsu_valid = 1'b0;
      step();
      chk64($sformatf("rr%0d_rsp", r), {62'h0, ifu_rsp_valid, lsu_rsp_valid}, {62'h0, ~exp_lsu, exp_lsu});
      step();
    end

    // MEM_LAT=3 load on the second instance.
    lsu_wren = 1'b0; lsu_addr = 64'h8000_3000; lsu_valid3 = 1'b1; #1;
    chk1("l3_ready", lsu_ready3, 1'b1);
    step();
    lsu_valid3 = 1'b0; lsu_addr = 64'h0;
    for (int i = 0; i < 3; i++) begin
      lsu_valid3 = (i == 1);
      #1;
      chk1($sformatf("l3_wait%0d_ready", i), lsu_ready3, 1'b0);
      chk1($sformatf("l3_wait%0d_rsp", i), lsu_rsp_valid3, 1'b0);
      step();
    end
    lsu_valid3 = 1'b0;
    chk1("l3_rsp_valid", lsu_rsp_valid3, 1'b1);
    chk64("l3_rsp_data", lsu_rsp_data3, 64'h8000_5222);
    chk64("l3_rd_addr", rd_load3, 64'h8000_3000);
    step();
    chk1("l3_rsp_end", lsu_rsp_valid3, 1'b0);
    step(); step(); step();

    // Reset asserted mid-BUSY on a store.
    lsu_valid = 1'b1; lsu_wren = 1'b1; lsu_addr = 64'h8000_1008;
    lsu_wdata = 64'h1234_5678; lsu_len = 8'd8;
    step();
    lsu_valid = 1'b0;
    chk1("r_wr_en_busy", wr_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("r_outputs_zero", |{ifu_ready, lsu_ready, ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid,
                             lsu_rsp_data, rd_inst, rd_load, wr_en, wr_addr, wr_data, wr_len}, 1'b0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1($sformatf("r_no_rsp%0d", i), lsu_rsp_valid, 1'b0);
    end
    ifu_valid = 1'b1; ifu_addr = 64'h8000_0000; #1;
    chk1("r_next_ready", ifu_ready, 1'b1);
    step();
    ifu_valid = 1'b0;
    step();
    chk1("r_next_rsp", ifu_rsp_valid, 1'b1);
    chk64("r_next_data", ifu_rsp_data, 64'h0010_0073);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single simulation memory port (the DPI memory bridge) between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle core.
- Accepts one request at a time over valid/ready handshakes, holds address and data stable toward the bridge for a fixed number of cycles, then returns a one-cycle response pulse to the granted requester.
- Issues exactly one write per store, so the bridge never sees duplicate write events.

Parameters:
ADDR_W, 64, address width of requesters and memory port
DATA_W, 64, data width
MEM_LAT, 1, cycles the memory address is held before read data is sampled; legal range 1..15

Ports:
iClk  in  1  clock
iResetN  in  1  reset, asynchronous, active-low
iIfuReqValid  in  1  IFU fetch request
oIfuReqReady  out  1  IFU request accepted this cycle when high with valid
iIfuAddr  in  ADDR_W  fetch address
oIfuRspValid  out  1  one-cycle fetch response pulse
oIfuRspData  out  DATA_W  fetched data, valid with oIfuRspValid
iLsuReqValid  in  1  LSU request
oLsuReqReady  out  1  LSU request accepted this cycle
iLsuWrEn  in  1  1 = store, 0 = load
iLsuAddr  in  ADDR_W  load/store address
iLsuWrData  in  DATA_W  store data
iLsuWrLen  in  8  store length in bytes: 1, 2, 4 or 8
oLsuRspValid  out  1  one-cycle load data or store completion pulse
oLsuRspData  out  DATA_W  load data; 0 for stores
oMemRdAddrInst  out  ADDR_W  address to the bridge instruction-read path
oMemRdAddrLoad  out  ADDR_W  address to the bridge load-read path
iMemRdDataInst  in  DATA_W  bridge instruction-read data (combinational)
iMemRdDataLoad  in  DATA_W  bridge load-read data (combinational)
oMemWrEn  out  1  write strobe to the bridge
oMemWrAddr  out  ADDR_W  write address
oMemWrData  out  DATA_W  write data
oMemWrLen  out  8  write length

Behaviour:
- Reset (asynchronous, iResetN low):
  - FSM goes to IDLE.
  - All outputs are 0, including addresses, data and the response pulses.
  - Any in-flight request is dropped and no response is produced.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - ReadyOut is high only for the winner of arbitration; the loser sees ready 0.
  - Arbitration: if only one requester is valid it wins; if both are valid, the LSU wins (fixed priority).
  - On valid && ready, the request (owner, addr, wren, wdata, len) is captured into registers and the FSM moves to BUSY with the counter set to MEM_LAT-1.
  - No request in IDLE: the FSM stays in IDLE.
- BUSY:
  - Both ready outputs are 0.
  - Owner IFU: oMemRdAddrInst is driven from the captured address.
  - Owner LSU load: oMemRdAddrLoad is driven from the captured address.
  - Owner LSU store: oMemWrEn is high for the first BUSY cycle only. oMemWrAddr, oMemWrData and oMemWrLen are held for all of BUSY.
  - The counter decrements each cycle. When the counter is 0, read data from the owner's path is registered and the FSM moves to RESP.
- RESP:
  - The owner's RspValid is high for exactly one cycle, with the registered data (0 for stores).
  - The FSM returns to IDLE.
  - There is no response backpressure; the requester must accept the pulse.
- Latency: a handshake at edge N gives RspValid high in the cycle after edge N+MEM_LAT (MEM_LAT+1 cycles from acceptance). Throughput is one request per MEM_LAT+2 cycles.
- Address outputs hold their last driven value after BUSY, so the bridge sees no spurious address change. Read addresses change only when a new request of that type enters BUSY.
- oMemWrEn is 0 in IDLE and RESP.
- An iLsuWrLen outside {1,2,4,8} is passed through unchanged; the bridge defines the result.
- Inputs changing during BUSY or RESP have no effect; only the captured values are used.

Optional Feature:
MEM_ARB_RR_EN
- Defined: when both requesters are valid in the same cycle, a one-bit last-grant pointer selects the requester not granted last. The pointer updates on every accepted request and resets to "LSU last", so the first tie goes to the IFU. A single valid requester always wins.
- Undefined: fixed LSU priority as above, and no pointer register exists.

Test Plan:
- Reset, then IFU fetch at 0x80000000 with the bridge returning 0x00100073, MEM_LAT=1 -> oIfuReqReady high in the request cycle; oMemRdAddrInst=0x80000000 for 1 cycle; oIfuRspValid pulses 2 cycles after acceptance with data 0x00100073.
- LSU store addr 0x80001000, data 0xDEADBEEF, len 4 -> oMemWrEn high exactly 1 cycle with addr, data and len stable; oLsuRspValid pulses with data 0; oIfuRspValid stays 0.
- IFU and LSU load requested in the same cycle, macro undefined -> LSU served first; IFU accepted in the next IDLE; two responses in order LSU, then IFU.
- Same stimulus with MEM_ARB_RR_EN defined, repeated 4 times -> grants alternate IFU, LSU, IFU, LSU, …
- MEM_LAT=3, load issued -> RspValid exactly 4 cycles after the handshake; ready 0 for all intervening cycles.
- iResetN asserted low mid-BUSY on a store -> all outputs 0 immediately; no RspValid after release; the next request is served normally.
